// File: rtl/dma_oam.sv
// OAM DMA engine: copies OAM_LEN bytes from page {reg,00} to FE00.. one byte per
// READ/WRITE pair, with echo-RAM page folding and restart on any FF46 write.
module dma_oam #(
    parameter int unsigned OAM_LEN     = 160,
    parameter int unsigned START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr_en,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        src_rd,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_rdata,
    input  logic        src_valid,
    output logic        oam_wr,
    output logic [15:0] oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        dma_active
);

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [7:0]  LAST_IDX     = 8'(OAM_LEN - 1);
    localparam int unsigned CW           = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [CW-1:0] LAST_WAIT  = CW'((START_DELAY > 0) ? (START_DELAY - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } state_t;

    state_t        state;
    logic [7:0]    dma_reg;
    logic [7:0]    page;
    logic [7:0]    idx;
    logic [CW-1:0] wait_cnt;

    logic          dma_wr_c;
    logic [7:0]    eff_page_c;

    // Register write decode and echo-RAM page folding (E0..FF mirror C0..DF)
    assign dma_wr_c   = cpu_wr_en && (cpu_addr == DMA_REG_ADDR);
    assign eff_page_c = (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;
    assign cpu_rdata  = dma_reg;

    // Transfer sequencer with registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dma_reg    <= 8'hFF;
            page       <= 8'h00;
            idx        <= 8'h00;
            wait_cnt   <= '0;
            src_rd     <= 1'b0;
            src_addr   <= 16'h0000;
            oam_wr     <= 1'b0;
            oam_addr   <= 16'h0000;
            oam_wdata  <= 8'h00;
            dma_active <= 1'b0;
        end else begin
            oam_wr <= 1'b0;
            if (dma_wr_c) begin
                // Start or restart; a byte arriving this cycle is dropped, while a
                // WRITE-state strobe already on the bus completes normally.
                dma_reg    <= cpu_wdata;
                page       <= eff_page_c;
                idx        <= 8'h00;
                wait_cnt   <= '0;
                dma_active <= 1'b1;
                if (START_DELAY == 0) begin
                    state    <= READ;
                    src_rd   <= 1'b1;
                    src_addr <= {eff_page_c, 8'h00};
                end else begin
                    state    <= START;
                    src_rd   <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        src_rd     <= 1'b0;
                        dma_active <= 1'b0;
                    end
                    START: begin
                        if (wait_cnt == LAST_WAIT) begin
                            state    <= READ;
                            src_rd   <= 1'b1;
                            src_addr <= {page, idx};
                        end else begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
                    end
                    READ: begin
                        if (src_valid) begin
                            state     <= WRITE;
                            src_rd    <= 1'b0;
                            oam_wr    <= 1'b1;
                            oam_addr  <= OAM_BASE + 16'(idx);
                            oam_wdata <= src_rdata;
                        end
                    end
                    WRITE: begin
                        if (idx == LAST_IDX) begin
                            state      <= IDLE;
                            dma_active <= 1'b0;
                        end else begin
                            state    <= READ;
                            idx      <= idx + 8'd1;
                            src_rd   <= 1'b1;
                            src_addr <= {page, idx + 8'd1};
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        src_rd     <= 1'b0;
                        dma_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dma_oam.md
DMA_OAM -- requirements
Module: dma_oam

Interface
REQ-001 SHALL have parameter OAM_LEN, default 160, giving the number of bytes per transfer (legal range 1..256).
REQ-002 SHALL have parameter START_DELAY, default 1, giving the clocks spent in START before the first source read (0 allowed).
REQ-003 SHALL have one clock and an asynchronous, active-low reset. No other clock or reset SHALL exist.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cpu_addr  in  16  CPU register-port address.
REQ-007 cpu_wr_en  in  1  CPU write strobe, single clock.
REQ-008 cpu_wdata  in  8  CPU write data.
REQ-009 cpu_rdata  out  8  DMA register readback, combinational from the register.
REQ-010 src_rd  out  1  source read request, held until accepted.
REQ-011 src_addr  out  16  source byte address.
REQ-012 src_rdata  in  8  source read data.
REQ-013 src_valid  in  1  source data valid; completes a read when seen with src_rd high.
REQ-014 oam_wr  out  1  OAM write strobe, single clock.
REQ-015 oam_addr  out  16  OAM destination address, 16'hFE00 + idx.
REQ-016 oam_wdata  out  8  OAM write data.
REQ-017 dma_active  out  1  high in every state except IDLE; the MMU uses it to block CPU access outside HRAM.

Function
REQ-018 SHALL hold an 8-bit DMA register. A write with cpu_addr == 16'hFF46 SHALL load cpu_wdata into it. cpu_rdata SHALL always return the register.
REQ-019 SHALL derive the effective source page from the register. Pages 8'hE0..8'hFF SHALL map to page - 8'h20 (echo mirror). All other pages SHALL pass unchanged.
REQ-020 SHALL implement the states IDLE, START, READ and WRITE, with an 8-bit byte index idx.
REQ-021 IDLE: on an FF46 write, go to START with idx = 0 and latch the effective page.
REQ-022 START: count START_DELAY clocks, then go to READ. With START_DELAY = 0, go to READ on the next clock.
REQ-023 READ: src_rd = 1 and src_addr = {page, idx}. When src_valid is high, capture src_rdata and go to WRITE.
REQ-024 WRITE: assert oam_wr for exactly one clock with oam_addr = 16'hFE00 + idx and oam_wdata = the captured byte.
REQ-025 After WRITE: if idx == OAM_LEN-1, go to IDLE; otherwise increment idx and go to READ.
REQ-026 Latency: one byte takes at least 2 clocks (READ then WRITE) plus the source wait. A full zero-wait transfer SHALL take START_DELAY + 2*OAM_LEN clocks from the write to the return to IDLE.
REQ-027 An FF46 write in any non-IDLE state SHALL restart the transfer: new page, idx = 0, go to START.
REQ-028 A restart SHALL take priority over a same-cycle src_valid: the byte is discarded and no oam_wr is issued for it.
REQ-029 A restart SHALL take priority over WRITE: the pending oam_wr in that cycle SHALL still issue, then the block goes to START.
REQ-030 src_rd SHALL be low in IDLE, START and WRITE. src_valid outside READ SHALL be ignored.
REQ-031 idx SHALL never exceed OAM_LEN-1. oam_addr SHALL never exceed 16'hFE00 + OAM_LEN-1.
REQ-032 Writes to any address other than FF46 SHALL have no effect on the block.

Reset
REQ-033 While rst_n is low, the block SHALL be in IDLE with idx = 0, DMA register = 8'hFF, and src_rd = oam_wr = dma_active = 0.
REQ-034 On reset, src_addr, oam_addr and oam_wdata SHALL be 0, and cpu_rdata SHALL be 8'hFF.
REQ-035 Asserting reset mid-transfer SHALL abort immediately with no further oam_wr. Releasing reset SHALL leave the block in IDLE until the next FF46 write.

Verification
REQ-036 Basic transfer: write 8'hC1 to FF46 with src_valid tied high.
- Reads SHALL go to C100..C19F.
- 160 oam_wr pulses SHALL write FE00..FE9F with the matching data.
- dma_active SHALL be high for exactly 321 clocks.
REQ-037 Echo mirror: write 8'hE3 to FF46. Reads SHALL go to C300..C39F, and cpu_rdata SHALL read 8'hE3.
REQ-038 Source wait: in READ, hold src_valid low for 3 clocks.
- src_rd and src_addr SHALL stay stable during the wait.
- No oam_wr SHALL occur until one clock after src_valid.
REQ-039 Restart: write 8'h80 to FF46, then write 8'h90 after 10 bytes, in the same cycle as src_valid.
- That byte SHALL be dropped.
- The next reads SHALL start at 9000.
- The final oam_wr count from the restart SHALL be 160.
REQ-040 Mid-transfer reset: drop rst_n at byte 50.
- All outputs SHALL return to reset values asynchronously.
- No oam_wr SHALL occur after reset is released without a new FF46 write.
REQ-041 Non-target write: write to FF47 while IDLE. There SHALL be no state change, and cpu_rdata SHALL stay 8'hFF.
